// File: rtl/distance_delta_engine_pkg.sv
// Shared types, term tables and triangular addressing for the tour-length delta engine.
package distance_delta_engine_pkg;

  typedef enum logic {TWO_OPT = 1'b0, OR_OPT = 1'b1} distance_mode_t;

  typedef enum logic [2:0] {SEL_K, SEL_KP, SEL_KM, SEL_L, SEL_LP, SEL_LM} term_sel_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} eng_state_t;

  typedef struct packed {
    term_sel_t sel_a;
    term_sel_t sel_b;
    logic      neg;
  } term_desc_t;

  localparam int MAX_TERMS     = 6;
  localparam int TWO_OPT_TERMS = 4;
  localparam int OR_OPT_TERMS  = 6;

  // Unused tail entries of the 2-opt table are never reached.
  localparam term_desc_t TWO_OPT_TBL [MAX_TERMS] = '{
    '{SEL_KM, SEL_L,  1'b0}, '{SEL_K, SEL_LP, 1'b0},
    '{SEL_KM, SEL_K,  1'b1}, '{SEL_L, SEL_LP, 1'b1},
    '{SEL_K,  SEL_K,  1'b0}, '{SEL_K, SEL_K,  1'b0}};

  localparam term_desc_t OR_OPT_TBL [MAX_TERMS] = '{
    '{SEL_KM, SEL_KP, 1'b0}, '{SEL_L, SEL_K,  1'b0},
    '{SEL_K,  SEL_LP, 1'b0}, '{SEL_KM, SEL_K, 1'b1},
    '{SEL_K,  SEL_KP, 1'b1}, '{SEL_L, SEL_LP, 1'b1}};

  function automatic int unsigned tri_addr(input int unsigned a, input int unsigned b);
    return (a == 0) ? b : (a * (a - 1)) / 2 + b;
  endfunction

endpackage

// File: rtl/distance_delta_engine_tri_addr.sv
// Pair stage: orders two cities and registers the triangular distance address.
module distance_tri_addr
  import distance_delta_engine_pkg::*;
#(
  parameter int CITY_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  vld_i,
  input  logic [CITY_W-1:0]     city_a_i,
  input  logic [CITY_W-1:0]     city_b_i,
  input  logic                  neg_i,
  input  logic                  last_i,
  output logic                  vld_o,
  output logic                  rd_en_o,
  output logic [2*CITY_W-1:0]   rd_addr_o,
  output logic                  neg_o,
  output logic                  last_o
);

  localparam int ADDR_W = 2 * CITY_W;

  logic [CITY_W-1:0] hi, lo;
  logic              vld_q, rd_q, neg_q, last_q;
  logic [ADDR_W-1:0] addr_q;

  always_comb begin
    hi = (city_a_i > city_b_i) ? city_a_i : city_b_i;
    lo = (city_a_i > city_b_i) ? city_b_i : city_a_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_i;
      rd_q   <= vld_i && (city_a_i != city_b_i);
      addr_q <= ADDR_W'(tri_addr(32'(hi), 32'(lo)));
    end
  end

  always_ff @(posedge clk_i) begin
    neg_q  <= neg_i;
    last_q <= last_i;
  end

  assign vld_o     = vld_q;
  assign rd_en_o   = rd_q;
  assign rd_addr_o = addr_q;
  assign neg_o     = neg_q;
  assign last_o    = last_q;

endmodule

// File: rtl/distance_delta_engine.sv
// Sequences ordering/distance RAM reads for one 2-opt or or-opt proposal and accumulates the delta.
module distance_delta_engine
  import distance_delta_engine_pkg::*;
#(
  parameter int CITY_NUM = 32,
  parameter int CITY_W   = $clog2(CITY_NUM),
  parameter int DIST_W   = 18,
  parameter int DELTA_W  = DIST_W + 3,
  parameter int ORD_LAT  = 2,
  parameter int DIST_LAT = 2,
  parameter int TAG_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic                      start_mode,
  input  logic [CITY_W-1:0]         start_k,
  input  logic [CITY_W-1:0]         start_l,
  input  logic [TAG_W-1:0]          start_tag,
  output logic                      ord_rd_en,
  output logic [CITY_W-1:0]         ord_rd_addr,
  input  logic [CITY_W-1:0]         ord_rd_data,
  output logic                      dist_rd_en,
  output logic [2*CITY_W-1:0]       dist_rd_addr,
  input  logic [DIST_W-1:0]         dist_rd_data,
  output logic                      delta_valid,
  input  logic                      delta_ready,
  output logic signed [DELTA_W-1:0] delta,
  output logic [TAG_W-1:0]          delta_tag,
  output logic                      delta_err,
  output logic                      busy
);

  localparam int CNT_W = 4;

  typedef struct packed { logic second; logic neg; logic last; } ord_sb_t;
  typedef struct packed { logic zero;   logic neg; logic last; } dist_sb_t;

  eng_state_t                 state_q, state_d;
  distance_mode_t             mode_q, mode_d;
  logic [CITY_W-1:0]          k_q, k_d, l_q, l_d;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic signed [DELTA_W-1:0]  acc_q, acc_d;

  function automatic logic [CITY_W-1:0] pos_inc(input logic [CITY_W-1:0] p);
    return (int'(p) == CITY_NUM - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [CITY_W-1:0] pos_dec(input logic [CITY_W-1:0] p);
    return (p == '0) ? CITY_W'(CITY_NUM - 1) : p - 1'b1;
  endfunction

  logic req_illegal;
  assign req_illegal = (int'(start_k) >= CITY_NUM) || (int'(start_l) >= CITY_NUM) ||
                       (start_k == start_l) ||
                       ((distance_mode_t'(start_mode) == OR_OPT) && (start_l == pos_dec(start_k)));

  // Issue decode: even count reads a term's first city, odd count its second.
  term_desc_t        term;
  term_sel_t         sel;
  logic [CITY_W-1:0] issue_pos;
  logic              last_rd;

  always_comb begin
    term = (mode_q == OR_OPT) ? OR_OPT_TBL[cnt_q[3:1]] : TWO_OPT_TBL[cnt_q[3:1]];
    sel  = cnt_q[0] ? term.sel_b : term.sel_a;
    issue_pos = k_q;
    case (sel)
      SEL_KP:  issue_pos = pos_inc(k_q);
      SEL_KM:  issue_pos = pos_dec(k_q);
      SEL_L:   issue_pos = l_q;
      SEL_LP:  issue_pos = pos_inc(l_q);
      SEL_LM:  issue_pos = pos_dec(l_q);
      default: issue_pos = k_q;
    endcase
    last_rd = (cnt_q == ((mode_q == OR_OPT) ? CNT_W'(2 * OR_OPT_TERMS - 1)
                                            : CNT_W'(2 * TWO_OPT_TERMS - 1)));
  end

  // Stage p0: registered ordering read
  logic              ord_en_q;
  logic [CITY_W-1:0] ord_addr_q;
  ord_sb_t           ord_sb_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ord_en_q   <= 1'b0;
      ord_addr_q <= '0;
    end else begin
      ord_en_q   <= (state_q == S_ISSUE);
      ord_addr_q <= issue_pos;
    end
  end

  always_ff @(posedge clk) ord_sb_q <= '{second: cnt_q[0], neg: term.neg, last: last_rd};

  // Stage p1: ordering latency match
  logic    ord_vld_sh_q [ORD_LAT];
  ord_sb_t ord_sb_sh_q  [ORD_LAT];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ORD_LAT; i++) ord_vld_sh_q[i] <= 1'b0;
    end else begin
      ord_vld_sh_q[0] <= ord_en_q;
      for (int i = 1; i < ORD_LAT; i++) ord_vld_sh_q[i] <= ord_vld_sh_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    ord_sb_sh_q[0] <= ord_sb_q;
    for (int i = 1; i < ORD_LAT; i++) ord_sb_sh_q[i] <= ord_sb_sh_q[i-1];
  end

  logic              ord_hit;
  ord_sb_t           ord_hit_sb;
  logic [CITY_W-1:0] first_q;

  assign ord_hit    = ord_vld_sh_q[ORD_LAT-1];
  assign ord_hit_sb = ord_sb_sh_q[ORD_LAT-1];

  always_ff @(posedge clk) begin
    if (ord_hit && !ord_hit_sb.second) first_q <= ord_rd_data;
  end

  // Stage p2: pair ordering and triangular address
  logic pair_vld, pair_neg, pair_last;

  distance_tri_addr #(.CITY_W(CITY_W)) u_tri (
    .clk_i     (clk),
    .rst_ni    (reset),
    .vld_i     (ord_hit && ord_hit_sb.second),
    .city_a_i  (first_q),
    .city_b_i  (ord_rd_data),
    .neg_i     (ord_hit_sb.neg),
    .last_i    (ord_hit_sb.last),
    .vld_o     (pair_vld),
    .rd_en_o   (dist_rd_en),
    .rd_addr_o (dist_rd_addr),
    .neg_o     (pair_neg),
    .last_o    (pair_last)
  );

  // Stage p3: distance latency match; a skipped read still occupies its slot
  logic     dist_vld_sh_q [DIST_LAT];
  dist_sb_t dist_sb_sh_q  [DIST_LAT];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DIST_LAT; i++) dist_vld_sh_q[i] <= 1'b0;
    end else begin
      dist_vld_sh_q[0] <= pair_vld;
      for (int i = 1; i < DIST_LAT; i++) dist_vld_sh_q[i] <= dist_vld_sh_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dist_sb_sh_q[0] <= '{zero: !dist_rd_en, neg: pair_neg, last: pair_last};
    for (int i = 1; i < DIST_LAT; i++) dist_sb_sh_q[i] <= dist_sb_sh_q[i-1];
  end

  logic                      acc_hit;
  dist_sb_t                  acc_sb;
  logic signed [DELTA_W-1:0] dist_term;

  assign acc_hit   = dist_vld_sh_q[DIST_LAT-1];
  assign acc_sb    = dist_sb_sh_q[DIST_LAT-1];
  assign dist_term = signed'({{(DELTA_W - DIST_W){1'b0}}, dist_rd_data});

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    k_d     = k_q;
    l_d     = l_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    acc_d   = acc_q;
    if (acc_hit && !acc_sb.zero) acc_d = acc_sb.neg ? acc_q - dist_term : acc_q + dist_term;
    case (state_q)
      S_IDLE: if (start_valid) begin
        mode_d  = distance_mode_t'(start_mode);
        k_d     = start_k;
        l_d     = start_l;
        tag_d   = start_tag;
        cnt_d   = '0;
        acc_d   = '0;
        err_d   = req_illegal;
        state_d = req_illegal ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (last_rd) state_d = S_DRAIN;
      end
      S_DRAIN: if (acc_hit && acc_sb.last) state_d = S_DONE;
      S_DONE:  if (delta_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= TWO_OPT;
      k_q     <= '0;
      l_q     <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      l_q     <= l_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign delta_valid = (state_q == S_DONE);
  assign delta       = acc_q;
  assign delta_tag   = tag_q;
  assign delta_err   = err_q;
  assign ord_rd_en   = ord_en_q;
  assign ord_rd_addr = ord_addr_q;

endmodule

// File: tb/tb_distance_delta_engine.sv
// Directed and randomized checks of distance_delta_engine against a tour-level delta model.
module tb_distance_delta_engine;

  localparam int N = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start_valid, start_ready, start_mode;
  logic [2:0]         start_k, start_l;
  logic [3:0]         start_tag;
  logic               ord_rd_en;
  logic [2:0]         ord_rd_addr, ord_rd_data;
  logic               dist_rd_en;
  logic [5:0]         dist_rd_addr;
  logic [17:0]        dist_rd_data;
  logic               delta_valid, delta_ready, delta_err, busy;
  logic signed [20:0] delta;
  logic [3:0]         delta_tag;

  distance_delta_engine #(
    .CITY_NUM(N), .DIST_W(18), .ORD_LAT(2), .DIST_LAT(2), .TAG_W(4)
  ) dut (
    .clk(clk), .reset(rst_n),
    .start_valid(start_valid), .start_ready(start_ready), .start_mode(start_mode),
    .start_k(start_k), .start_l(start_l), .start_tag(start_tag),
    .ord_rd_en(ord_rd_en), .ord_rd_addr(ord_rd_addr), .ord_rd_data(ord_rd_data),
    .dist_rd_en(dist_rd_en), .dist_rd_addr(dist_rd_addr), .dist_rd_data(dist_rd_data),
    .delta_valid(delta_valid), .delta_ready(delta_ready), .delta(delta),
    .delta_tag(delta_tag), .delta_err(delta_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int          ord_m [N];
  int          dist_tab [N][N];
  logic [17:0] dist_mem [64];
  logic [2:0]  ord_p1, ord_p2;
  logic [17:0] dist_p1, dist_p2;
  int          ord_cnt = 0;
  int          dist_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Two-cycle read-latency RAM models
  always @(posedge clk) begin
    ord_p1  <= ord_rd_en ? 3'(ord_m[ord_rd_addr]) : 3'd0;
    ord_p2  <= ord_p1;
    dist_p1 <= dist_rd_en ? dist_mem[dist_rd_addr] : 18'd0;
    dist_p2 <= dist_p1;
    if (ord_rd_en)  ord_cnt  <= ord_cnt + 1;
    if (dist_rd_en) dist_cnt <= dist_cnt + 1;
  end
  assign ord_rd_data  = ord_p2;
  assign dist_rd_data = dist_p2;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) dist_mem[i] = '0;
    for (int a = 1; a < N; a++)
      for (int b = 0; b < a; b++) dist_mem[a * (a - 1) / 2 + b] = 18'(dist_tab[a][b]);
  endtask

  function automatic int wrap(input int p);
    return ((p % N) + N) % N;
  endfunction

  // Tour-level reference: signed sum of edge lengths added minus edges removed.
  task automatic model(input bit mode, input int k, input int l,
                       output int exp_delta, output bit exp_err, output int exp_dist);
    int pa [6], pb [6], sg [6], n, ca, cb;
    exp_delta = 0;
    exp_dist  = 0;
    exp_err   = (k == l) || (mode && (l == wrap(k - 1)));
    if (!mode) begin
      n = 4;
      pa = '{k - 1, k, k - 1, l, 0, 0};
      pb = '{l, l + 1, k, l + 1, 0, 0};
      sg = '{1, 1, -1, -1, 0, 0};
    end else begin
      n = 6;
      pa = '{k - 1, l, k, k - 1, k, l};
      pb = '{k + 1, k, l + 1, k, k + 1, l + 1};
      sg = '{1, 1, 1, -1, -1, -1};
    end
    if (exp_err) return;
    for (int t = 0; t < n; t++) begin
      ca = ord_m[wrap(pa[t])];
      cb = ord_m[wrap(pb[t])];
      if (ca != cb) begin
        exp_dist++;
        exp_delta += sg[t] * dist_tab[ca][cb];
      end
    end
  endtask

  task automatic do_job(input string nm, input bit mode, input int k, input int l,
                        input int tag, input int stall);
    int exp_delta, exp_dist, lat, o0, d0;
    bit exp_err;
    logic signed [20:0] hold;
    model(mode, k, l, exp_delta, exp_err, exp_dist);
    check({nm, " start_ready"}, start_ready, 1);
    start_valid = 1'b1;
    start_mode  = mode;
    start_k     = k[2:0];
    start_l     = l[2:0];
    start_tag   = tag[3:0];
    o0 = ord_cnt;
    d0 = dist_cnt;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 1;
    while (!delta_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, " latency"}, lat, exp_err ? 1 : (mode ? 19 : 15));
    check({nm, " delta"}, delta, exp_delta);
    check({nm, " err"}, delta_err, exp_err);
    check({nm, " tag"}, delta_tag, tag);
    check({nm, " ord_reads"}, ord_cnt - o0, exp_err ? 0 : (mode ? 12 : 8));
    check({nm, " dist_reads"}, dist_cnt - d0, exp_dist);
    hold = delta;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({nm, " stall_valid"}, delta_valid, 1);
      check({nm, " stall_delta"}, delta, hold);
      check({nm, " stall_tag"}, delta_tag, tag);
      check({nm, " stall_ready"}, start_ready, 0);
    end
    delta_ready = 1'b1;
    @(posedge clk); #1;
    delta_ready = 1'b0;
    check({nm, " consumed"}, delta_valid, 0);
    check({nm, " idle"}, busy, 0);
  endtask

  initial begin
    int seen, tmp, j;
    rst_n = 1'b0;
    start_valid = 1'b0;
    start_mode = 1'b0;
    start_k = '0;
    start_l = '0;
    start_tag = '0;
    delta_ready = 1'b0;
    for (int i = 0; i < N; i++) ord_m[i] = i;
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) dist_tab[a][b] = (a > b) ? 10 * a + b : 10 * b + a;
    fill_mem();

    repeat (3) @(posedge clk);
    #1;
    check("rst start_ready", start_ready, 1);
    check("rst delta_valid", delta_valid, 0);
    check("rst ord_rd_en", ord_rd_en, 0);
    check("rst dist_rd_en", dist_rd_en, 0);
    check("rst busy", busy, 0);
    check("rst delta", delta, 0);
    check("rst delta_tag", delta_tag, 0);
    check("rst delta_err", delta_err, 0);
    check("rst dist_rd_addr", dist_rd_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_job("two_opt_2_5", 1'b0, 2, 5, 1, 0);
    do_job("two_opt_wrap", 1'b0, 0, 7, 2, 0);
    do_job("or_opt_3_5", 1'b1, 3, 5, 6, 0);
    do_job("illegal_eq", 1'b0, 4, 4, 9, 0);
    do_job("stall", 1'b0, 2, 5, 3, 5);
    do_job("back2back", 1'b1, 3, 5, 12, 0);
    do_job("or_illegal_km", 1'b1, 0, 7, 5, 0);

    // Reset in cycle 6 of a job discards it
    start_valid = 1'b1;
    start_mode = 1'b0;
    start_k = 3'd1;
    start_l = 3'd4;
    start_tag = 4'd7;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst start_ready", start_ready, 1);
    check("midrst busy", busy, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (delta_valid) seen++;
    end
    check("midrst no_result", seen, 0);

    // Random tours and distance tables
    for (int r = 0; r < 4; r++) begin
      for (int i = N - 1; i > 0; i--) begin
        j = $urandom_range(i, 0);
        tmp = ord_m[i];
        ord_m[i] = ord_m[j];
        ord_m[j] = tmp;
      end
      for (int a = 1; a < N; a++)
        for (int b = 0; b < a; b++) begin
          tmp = $urandom_range(262143, 0);
          dist_tab[a][b] = tmp;
          dist_tab[b][a] = tmp;
        end
      fill_mem();
      for (int n = 0; n < 6; n++)
        do_job("random", 1'($urandom_range(1, 0)), $urandom_range(N - 1, 0),
               $urandom_range(N - 1, 0), $urandom_range(15, 0), $urandom_range(2, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
